ne_load_unload_fsm: RTL
=======================

Name: ne_load_unload_fsm

Overview:
- Input/output interface controller sitting directly upstream of the decoder's address-generator FSM.
- Accepts one codeword as ROWDEPTH beats of P channel LLRs and writes them row by row into the L memory.
- Holds the address generator cleared with loaden during the load, then pulses start and waits for SISOready.
- After decode completes, reads the hard-decision bits back out of the L memory and streams them out, one row per beat, using a valid/ready handshake.

Parameters:
- Z, 511, circulant size (codeword bits per block)
- P, 26, lanes per row (RCU count)
- ROWDEPTH, 20, rows per block; row r holds bits r*P..r*P+P-1
- P_LAST, Z-(P*(ROWDEPTH-1)) = 17, valid lanes in row ROWDEPTH-1
- ROWWIDTH, 5, row address width
- LLRW, 6, bits per LLR

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_llr  in  P*LLRW  lane k = bits [k*LLRW +: LLRW]
- loaden  out  1  to address generator; holds it in reset during load
- start  out  1  one-cycle pulse to address generator
- SISOready  in  1  decode-complete level from address generator
- wr_L  out  1  L-memory write strobe
- wr_addr  out  ROWWIDTH  L-memory write row
- wr_lane_en  out  P  per-lane write enable
- wr_data  out  P*LLRW  registered copy of the accepted in_llr
- rd_en  out  1  L-memory hard-decision read strobe
- rd_addr  out  ROWWIDTH  read row
- hd_in  in  P  hard-decision read data; valid exactly 1 cycle after rd_en
- out_valid  out  1  output beat valid
- out_ready  in  1  output consumer ready
- out_bits  out  P  hard decisions; lanes >= P_LAST forced to 0 on the last row
- out_last  out  1  out_valid on row ROWDEPTH-1
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, KICK, DECODE, UNL_RD, UNL_WAIT, UNL_OUT. All registers use synchronous active-high rst.
- Reset: state=IDLE; row=0; every output 0, including wr_data and out_bits.
- rst mid-operation aborts immediately; a partially loaded or unloaded codeword is discarded.
- IDLE: in_ready=0. in_valid=1 moves the FSM to LOAD with row=0. No beat is consumed in IDLE.
- LOAD: loaden=1, in_ready=1.
  - Each accepted beat: next cycle wr_L=1, wr_addr=row, wr_data=in_llr, wr_lane_en=mask(row), then row++.
  - mask(r) = all ones if r<ROWDEPTH-1, else lower P_LAST lanes only (0x1FFFF with default parameters).
  - Accepting row ROWDEPTH-1 moves the FSM to KICK. A gap in in_valid simply stalls the FSM.
- KICK (1 cycle): loaden=0, start=1. The last row's wr_L fires in this same cycle. Go to DECODE.
- DECODE: all strobes 0, in_ready=0. SISOready=1 moves the FSM to UNL_RD with row=0. There is no timeout.
- UNL_RD (1 cycle): rd_en=1, rd_addr=row. Go to UNL_WAIT.
- UNL_WAIT (1 cycle): at the clock edge ending this cycle, out_bits <= hd_in & mask(row). Go to UNL_OUT.
- UNL_OUT:
  - out_valid=1; out_last=(row==ROWDEPTH-1).
  - out_bits stays stable until the handshake.
  - On out_valid&&out_ready: if last row go to IDLE with row=0, else row++ and go to UNL_RD.
- Throughput and latency:
  - Load: 1 row/cycle.
  - Unload: 1 row per 3 cycles with out_ready=1.
  - rd_en to out_valid: 2 cycles.
- start is never asserted in a cycle with loaden=1. loaden deasserts exactly one cycle before start.
- A new codeword is accepted only after the full unload returns the FSM to IDLE.
- in_valid during DECODE or UNL_* is ignored (in_ready=0).
- Counter: row saturates by design; no wrap beyond ROWDEPTH-1 is ever reached.
- Width: row comparisons use the ROWWIDTH-bit counter against ROWDEPTH-1.

Decomposition:
- Shared package ne_dec_pkg holds:
  - Z, P, ROWDEPTH, P_LAST, ROWWIDTH, LLRW
  - state encoding: IDLE=0, LOAD=1, KICK=2, DECODE=3, UNL_RD=4, UNL_WAIT=5, UNL_OUT=6, with 3-bit width
- Sub-module ne_row_lane_mask: combinational row -> P-bit lane mask. It is shared with the address generator's rcu_en logic and used here for both wr_lane_en and out_bits masking.

Test Plan:
- Reset then 20 back-to-back beats (row r lanes = r) -> wr_L on 20 consecutive cycles, addr 0..19, loaden high throughout LOAD; start pulses exactly 1 cycle, the cycle after the last accept; wr_lane_en row 19 = 0x1FFFF.
- Load with in_valid dropped for 3 cycles after row 7 -> no writes during the gap; row 8 written once; total exactly 20 writes.
- Model SISOready rising 50 cycles after start; hd_in = row index replicated -> rd_en at addr 0..19; out_bits row 19 has lanes 17..25 = 0; out_last only on beat 20.
- Unload with out_ready low for 5 cycles on row 4 -> out_bits stable, no rd_en issued until the handshake; next rd_addr=5.
- rst asserted mid-LOAD at row 10, then a fresh codeword -> all outputs 0 the cycle after rst; the new load starts at wr_addr 0.
- in_valid held high during DECODE and UNL_OUT -> in_ready=0, no wr_L, no start until the unload finishes and IDLE->LOAD occurs.

Source files
------------

// File: rtl/ne_dec_pkg.sv
// ne_dec_pkg: shared decoder geometry and load/unload state encoding
package ne_dec_pkg;
    localparam int Z        = 511;
    localparam int P        = 26;
    localparam int ROWDEPTH = 20;
    localparam int P_LAST   = Z - P * (ROWDEPTH - 1);
    localparam int ROWWIDTH = 5;
    localparam int LLRW     = 6;
    localparam logic [ROWWIDTH-1:0] LAST_ROW  = ROWWIDTH'(ROWDEPTH - 1);
    localparam logic [P-1:0]        LAST_MASK = P'((64'd1 << P_LAST) - 64'd1);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        KICK     = 3'd2,
        DECODE   = 3'd3,
        UNL_RD   = 3'd4,
        UNL_WAIT = 3'd5,
        UNL_OUT  = 3'd6
    } state_t;
endpackage

// File: rtl/ne_row_lane_mask.sv
// ne_row_lane_mask: lanes holding real codeword bits for a given row
module ne_row_lane_mask
    import ne_dec_pkg::*;
(
    input  logic [ROWWIDTH-1:0] i_row,
    output logic [P-1:0]        o_mask
);
    assign o_mask = (i_row == LAST_ROW) ? LAST_MASK : '1;
endmodule

// File: rtl/ne_load_unload_fsm.sv
// ne_load_unload_fsm: loads one codeword into L memory, kicks the decoder, streams hard decisions back out
module ne_load_unload_fsm
    import ne_dec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P*LLRW-1:0]    in_llr,
    output logic                 loaden,
    output logic                 start,
    input  logic                 SISOready,
    output logic                 wr_L,
    output logic [ROWWIDTH-1:0]  wr_addr,
    output logic [P-1:0]         wr_lane_en,
    output logic [P*LLRW-1:0]    wr_data,
    output logic                 rd_en,
    output logic [ROWWIDTH-1:0]  rd_addr,
    input  logic [P-1:0]         hd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P-1:0]         out_bits,
    output logic                 out_last,
    output logic                 busy
);
    state_t              r_state;
    logic [ROWWIDTH-1:0] r_row;
    logic                r_in_ready;
    logic                r_loaden;
    logic                r_start;
    logic                r_wr_L;
    logic [ROWWIDTH-1:0] r_wr_addr;
    logic [P-1:0]        r_wr_lane_en;
    logic [P*LLRW-1:0]   r_wr_data;
    logic                r_rd_en;
    logic [ROWWIDTH-1:0] r_rd_addr;
    logic                r_out_valid;
    logic [P-1:0]        r_out_bits;
    logic                r_out_last;
    logic                r_busy;
    logic [P-1:0]        w_mask;

    ne_row_lane_mask u_mask (
        .i_row  (r_row),
        .o_mask (w_mask)
    );

    assign in_ready   = r_in_ready;
    assign loaden     = r_loaden;
    assign start      = r_start;
    assign wr_L       = r_wr_L;
    assign wr_addr    = r_wr_addr;
    assign wr_lane_en = r_wr_lane_en;
    assign wr_data    = r_wr_data;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign out_valid  = r_out_valid;
    assign out_bits   = r_out_bits;
    assign out_last   = r_out_last;
    assign busy       = r_busy;

    // Control FSM; every output is set on the transition into the state that owns it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_in_ready   <= 1'b0;
            r_loaden     <= 1'b0;
            r_start      <= 1'b0;
            r_wr_L       <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_lane_en <= '0;
            r_wr_data    <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_out_valid  <= 1'b0;
            r_out_bits   <= '0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wr_L  <= 1'b0;
            r_start <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_state    <= LOAD;
                    r_row      <= '0;
                    r_loaden   <= 1'b1;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b1;
                end
                LOAD: if (in_valid) begin
                    r_wr_L       <= 1'b1;
                    r_wr_addr    <= r_row;
                    r_wr_data    <= in_llr;
                    r_wr_lane_en <= w_mask;
                    if (r_row == LAST_ROW) begin
                        r_state    <= KICK;
                        r_loaden   <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_start    <= 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                KICK: r_state <= DECODE;
                DECODE: if (SISOready) begin
                    r_state   <= UNL_RD;
                    r_row     <= '0;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= '0;
                end
                UNL_RD: r_state <= UNL_WAIT;
                UNL_WAIT: begin
                    r_state     <= UNL_OUT;
                    r_out_bits  <= hd_in & w_mask;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_row == LAST_ROW);
                end
                UNL_OUT: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    if (r_row == LAST_ROW) begin
                        r_state <= IDLE;
                        r_row   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= UNL_RD;
                        r_row     <= r_row + 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_row + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
